// File: rtl/glb_port_arbiter.sv
// Round-robin arbiter sharing the single GLB SRAM port between N_REQ requesters,
// with burst lock, a starvation cap and a pipelined read return. Optional stall counters: GLB_ARB_PERF_EN.
module glb_port_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          lock_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ*32-1:0]       wdata_i,
    input  logic [N_REQ*4-1:0]        web_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [31:0]               rdata_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [31:0]               glb_addr_o,
    output logic [31:0]               glb_write_data_o,
    output logic [3:0]                glb_web_o,
    input  logic [31:0]               glb_read_data_i,
    output logic                      busy_o,
    output logic                      dbg_state_o
`ifdef GLB_ARB_PERF_EN
    ,
    input  logic                      perf_clr_i,
    output logic [N_REQ*16-1:0]       stall_cnt_o
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {ST_ARB = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [RD_LAT-1:0]  r_pv;
    logic [IDX_W-1:0]   r_pid [RD_LAT];

    logic               w_rr_found;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_hold_owner;
    logic               w_gnt_any;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [N_REQ-1:0]   w_gnt;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_web;
    logic               w_is_read;
    logic               w_others;
    logic [CNT_W-1:0]   w_beat_next;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[IDX_W-1:0];
    endfunction

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!w_rr_found && req_i[wrap_add(r_rr_ptr, off)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = wrap_add(r_rr_ptr, off);
            end
        end
    end

    // Reset gates the grant so nothing reaches the SRAM while rst_n is low.
    always_comb begin
        w_hold_owner = (r_state == ST_HOLD) && req_i[r_owner];
        w_gnt_idx    = w_hold_owner ? r_owner : w_rr_idx;
        w_gnt_any    = rst_n && (w_hold_owner || w_rr_found);
        w_gnt        = '0;
        if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
    end

    // Only the granted lane is selected, so X on idle lanes cannot leak out.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_web   = 4'hF;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_addr  = addr_i[i*ADDR_W +: ADDR_W];
                w_wdata = wdata_i[i*32 +: 32];
                w_web   = web_i[i*4 +: 4];
            end
        end
    end

    always_comb begin
        w_is_read   = w_gnt_any && (w_web == 4'hF);
        w_others    = |(req_i & ~w_gnt);
        w_beat_next = (r_beat_cnt >= CNT_W'(BURST_MAX)) ? CNT_W'(BURST_MAX)
                                                         : r_beat_cnt + CNT_W'(1);
    end

    assign gnt_o            = w_gnt;
    assign glb_addr_o       = 32'(w_addr);
    assign glb_write_data_o = w_wdata;
    assign glb_web_o        = w_web;
    assign dbg_state_o      = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else if (w_hold_owner) begin
            r_beat_cnt <= w_beat_next;
            if (!lock_i[r_owner] || ((w_beat_next == CNT_W'(BURST_MAX)) && w_others))
                r_state <= ST_ARB;
        end else if (w_gnt_any) begin
            // Fresh arbitration win, including the cycle a HOLD owner drops its request.
            r_rr_ptr <= wrap_add(w_gnt_idx, 1);
            if (lock_i[w_gnt_idx] && (BURST_MAX > 1 || !w_others)) begin
                r_state    <= ST_HOLD;
                r_owner    <= w_gnt_idx;
                r_beat_cnt <= CNT_W'(1);
            end else begin
                r_state <= ST_ARB;
            end
        end else begin
            r_state <= ST_ARB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int s = 0; s < RD_LAT; s++) r_pid[s] <= '0;
        end else begin
            r_pv[0]  <= w_is_read;
            r_pid[0] <= w_gnt_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s]  <= r_pv[s-1];
                r_pid[s] <= r_pid[s-1];
            end
        end
    end

    // The SRAM output register supplies the data in the cycle the tag arrives.
    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < N_REQ; i++)
            rvalid_o[i] = r_pv[RD_LAT-1] && (r_pid[RD_LAT-1] == IDX_W'(i));
        rdata_o = r_pv[RD_LAT-1] ? glb_read_data_i : 32'h0;
        busy_o  = w_gnt_any || (|r_pv);
    end

`ifdef GLB_ARB_PERF_EN
    logic [15:0] r_stall [N_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_stall[i] <= '0;
        end else if (perf_clr_i) begin
            for (int i = 0; i < N_REQ; i++) r_stall[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (req_i[i] && !w_gnt[i] && (r_stall[i] != 16'hFFFF))
                    r_stall[i] <= r_stall[i] + 16'd1;
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int i = 0; i < N_REQ; i++) stall_cnt_o[i*16 +: 16] = r_stall[i];
    end
`endif

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Bench for glb_port_arbiter: directed cycle vectors, per-cycle port scoreboard
// and a read-return scoreboard popped whenever rvalid_o is seen.
module tb_glb_port_arbiter;

  localparam int N_REQ = 3;
  localparam int ADDR_W = 32;
  localparam int BURST_MAX = 16;
  localparam int RD_LAT = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [N_REQ-1:0]        req_i, lock_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*32-1:0]     wdata_i;
  logic [N_REQ*4-1:0]      web_i;
  logic [N_REQ-1:0]        gnt_o, rvalid_o;
  logic [31:0]             rdata_o, glb_addr_o, glb_write_data_o, glb_read_data_i;
  logic [3:0]              glb_web_o;
  logic                    busy_o, dbg_state_o;
`ifdef GLB_ARB_PERF_EN
  logic                    perf_clr_i = 1'b0;
  logic [N_REQ*16-1:0]     stall_cnt_o;
`endif

  glb_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .web_i(web_i), .gnt_o(gnt_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .glb_addr_o(glb_addr_o), .glb_write_data_o(glb_write_data_o), .glb_web_o(glb_web_o),
    .glb_read_data_i(glb_read_data_i), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
`ifdef GLB_ARB_PERF_EN
    , .perf_clr_i(perf_clr_i), .stall_cnt_o(stall_cnt_o)
`endif
  );

  // GLB SRAM model, one-cycle synchronous read
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (glb_web_o != 4'hF)
      for (int b = 0; b < 4; b++)
        if (!glb_web_o[b]) mem[glb_addr_o[11:2]][b*8 +: 8] <= glb_write_data_o[b*8 +: 8];
    glb_read_data_i <= mem[glb_addr_o[11:2]];
  end

  // scoreboard
  logic [N_REQ+4+1+64-1:0] exp_q[$];
  logic [N_REQ+32-1:0]     exp_rd_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic rd_pending = 1'b0;

  logic [N_REQ*ADDR_W-1:0] s_addr = '0;
  logic [N_REQ*32-1:0]     s_wdata = '0;
  logic [N_REQ*4-1:0]      s_web = '1;

  always @(negedge clk) begin
    logic [N_REQ+4+1+64-1:0] e, a;
    logic [N_REQ+32-1:0] er, ar;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt_o, glb_web_o, busy_o, glb_addr_o, glb_write_data_o};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_ports @%0t: got gnt/web/busy/addr/wdata=%h required %h", $time, a, e);
      end
    end
    if (!rst_n) begin
      n_checks++;
      if ({rvalid_o, rdata_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_read @%0t: got rvalid=%b rdata=%h required 0/0", $time, rvalid_o, rdata_o);
      end
`ifdef GLB_ARB_PERF_EN
      n_checks++;
      if (stall_cnt_o !== '0) begin
        n_fail++;
        $display("FAIL reset_stall @%0t: got %h required 0", $time, stall_cnt_o);
      end
`endif
    end else if (rvalid_o !== '0) begin
      n_checks++;
      ar = {rvalid_o, rdata_o};
      if (exp_rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid @%0t: got rvalid=%b rdata=%h required no return", $time, rvalid_o, rdata_o);
      end else begin
        er = exp_rd_q.pop_front();
        if (ar !== er) begin
          n_fail++;
          $display("FAIL read_return @%0t: got %h required %h", $time, ar, er);
        end
      end
    end
  end

  // driver tasks
  task automatic cfg(input int i, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    s_addr[i*32 +: 32] = a;
    s_web[i*4 +: 4]    = w;
    s_wdata[i*32 +: 32] = d;
  endtask

  task automatic step(input logic rst, input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] lock,
                      input logic [N_REQ-1:0] exp_gnt, input logic expect_rd, input logic [31:0] exp_rdata);
    logic [3:0] ew;
    logic [31:0] ea, ed;
    logic exp_busy;
    @(posedge clk);
    #1;
    rst_n = rst; req_i = req; lock_i = lock;
    addr_i = s_addr; wdata_i = s_wdata; web_i = s_web;
    ew = 4'hF; ea = '0; ed = '0;
    for (int i = 0; i < N_REQ; i++)
      if (exp_gnt[i]) begin
        ew = s_web[i*4 +: 4]; ea = s_addr[i*32 +: 32]; ed = s_wdata[i*32 +: 32];
      end
    exp_busy = (exp_gnt != '0) || (rst && rd_pending);
    exp_q.push_back({exp_gnt, ew, exp_busy, ea, ed});
    if (expect_rd) exp_rd_q.push_back({exp_gnt, exp_rdata});
    rd_pending = rst && (exp_gnt != '0) && (ew == 4'hF);
  endtask

  task automatic idle();
    step(1'b1, '0, '0, '0, 1'b0, 32'h0);
  endtask

  logic [N_REQ-1:0] rr_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    rst_n = 1'b0; req_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0; web_i = '1;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    mem[16] = 32'hDEADBEEF;

    // reset with all requesting: no grant, idle port
    cfg(0, 32'h10, 4'h0,    32'hA0A0A0A0);
    cfg(1, 32'h14, 4'b1100, 32'hB1B1B1B1);
    cfg(2, 32'h18, 4'b0011, 32'hC2C2C2C2);
    step(1'b0, 3'b111, '0, '0, 1'b0, 32'h0);
    step(1'b0, 3'b111, '0, '0, 1'b0, 32'h0);
    idle();

    // round-robin over writes with mixed byte enables
    for (int k = 0; k < 6; k++) step(1'b1, 3'b111, '0, rr_seq[k], 1'b0, 32'h0);

    // single read, one-cycle return
    cfg(1, 32'h40, 4'hF, 32'h0);
    step(1'b1, 3'b010, '0, 3'b010, 1'b1, 32'hDEADBEEF);
    idle();

    // burst lock released by lock drop
    step(1'b1, 3'b100, '0, 3'b100, 1'b0, 32'h0);
    repeat (3) step(1'b1, 3'b101, 3'b001, 3'b001, 1'b0, 32'h0);
    step(1'b1, 3'b101, 3'b000, 3'b001, 1'b0, 32'h0);
    step(1'b1, 3'b100, '0, 3'b100, 1'b0, 32'h0);

    // starvation cap: 16 beats then the waiter
    cfg(1, 32'h14, 4'b1100, 32'hB1B1B1B1);
    repeat (16) step(1'b1, 3'b011, 3'b001, 3'b001, 1'b0, 32'h0);
    step(1'b1, 3'b011, 3'b001, 3'b010, 1'b0, 32'h0);
    idle();
    // lone owner is never released, then a late waiter hits the saturated counter
    repeat (40) step(1'b1, 3'b001, 3'b001, 3'b001, 1'b0, 32'h0);
    step(1'b1, 3'b011, 3'b001, 3'b001, 1'b0, 32'h0);
    step(1'b1, 3'b011, 3'b001, 3'b010, 1'b0, 32'h0);
    idle();

    // write then read back the same word
    cfg(2, 32'h100, 4'h0, 32'h12345678);
    step(1'b1, 3'b100, '0, 3'b100, 1'b0, 32'h0);
    cfg(0, 32'h100, 4'hF, 32'h0);
    step(1'b1, 3'b001, '0, 3'b001, 1'b1, 32'h12345678);
    idle();

    // owner drops its request while holding: re-arbitrate in the same cycle
    cfg(0, 32'h10, 4'h0, 32'hA0A0A0A0);
    step(1'b1, 3'b001, 3'b001, 3'b001, 1'b0, 32'h0);
    step(1'b1, 3'b010, '0, 3'b010, 1'b0, 32'h0);
    idle();

    // back-to-back reads from different requesters return in order
    cfg(0, 32'h40, 4'hF, 32'h0);
    cfg(1, 32'h100, 4'hF, 32'h0);
    step(1'b1, 3'b011, '0, 3'b001, 1'b1, 32'hDEADBEEF);
    step(1'b1, 3'b010, '0, 3'b010, 1'b1, 32'h12345678);
    idle();
    idle();

    // reset the cycle after a read grant: the read must vanish
    step(1'b1, 3'b001, '0, 3'b001, 1'b0, 32'h0);
    step(1'b0, 3'b111, '0, '0, 1'b0, 32'h0);
    step(1'b0, 3'b111, '0, '0, 1'b0, 32'h0);
    repeat (3) idle();
    cfg(0, 32'h10, 4'h0, 32'hA0A0A0A0);
    cfg(1, 32'h14, 4'b1100, 32'hB1B1B1B1);
    step(1'b1, 3'b011, '0, 3'b001, 1'b0, 32'h0);
    idle();
    idle();

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d port and %0d read entries left, required 0/0", exp_q.size(), exp_rd_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
